// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_sched_pkg;

    localparam int unsigned DATA_W  = 9;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned LANE_W  = DATA_W - 1;

    typedef enum logic [1:0] {
        OP_XOR     = 2'b00,
        OP_XOR_ALT = 2'b01,
        OP_AND     = 2'b10,
        OP_ADD     = 2'b11
    } alu_op_e;

    // Operation presented to the shared ALU after arbitration.
    typedef struct packed {
        alu_op_e             op;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
    } alu_req_t;

endpackage

// File: rtl/alu_sched_alu.sv
// Shared ALU datapath: 8-bit lane operation, top result bit always zero.
module alu_sched_alu
    import alu_sched_pkg::*;
(
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic [LANE_W-1:0] a_lo;
    logic [LANE_W-1:0] b_lo;
    logic [LANE_W-1:0] lane;

    assign a_lo = a[LANE_W-1:0];
    assign b_lo = b[LANE_W-1:0];

    // ADD wraps within the lane; the carry is dropped by the lane width.
    always_comb begin
        lane = a_lo ^ b_lo;
        case (op)
            OP_AND:  lane = a_lo & b_lo;
            OP_ADD:  lane = a_lo + b_lo;
            default: lane = a_lo ^ b_lo;
        endcase
    end

    assign result = {1'b0, lane};

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; purely combinational, pointer is held by the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        gnt    = 2'b00;
        winner = 1'b0;
        if (en) begin
            case (req)
                2'b01: begin
                    gnt    = 2'b01;
                    winner = 1'b0;
                end
                2'b10: begin
                    gnt    = 2'b10;
                    winner = 1'b1;
                end
                2'b11: begin
                    gnt    = prio ? 2'b10 : 2'b01;
                    winner = prio;
                end
                default: begin
                    gnt    = 2'b00;
                    winner = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one ALU between two requesters, with a single
// registered result slot and per-requester grant counters.
module alu_scheduler #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][1:0]        req_op,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_W-1:0]      res_data,
    output logic                   res_id,
    output logic [CNT_W-1:0]       grant_cnt0,
    output logic [CNT_W-1:0]       grant_cnt1
);
    import alu_sched_pkg::*;

    logic       prio;
    logic       slot_free;
    logic       arb_en;
    logic [1:0] gnt;
    logic       winner;
    logic       accept;

    alu_req_t          sel;
    logic [DATA_W-1:0] alu_res;

    assign slot_free = !res_valid || res_ready;
    assign arb_en    = slot_free && !rst;

    rr_arb2 u_arb (
        .req    (req_valid),
        .en     (arb_en),
        .prio   (prio),
        .gnt    (gnt),
        .winner (winner)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    // Steer the winning requester's operation onto the shared ALU.
    always_comb begin
        sel.op = alu_op_e'(req_op[winner]);
        sel.a  = req_a[winner];
        sel.b  = req_b[winner];
    end

    alu_sched_alu u_alu (
        .op     (sel.op),
        .a      (sel.a),
        .b      (sel.b),
        .result (alu_res)
    );

    // Result slot: an accept overwrites (covering simultaneous drain), otherwise a drain empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            prio       <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_data  <= alu_res;
            res_id    <= winner;
            prio      <= ~winner;
            if (winner) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end else begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
